// File: rtl/alu_exec_unit.sv
// ALU/branch execution unit: computes issued ops, queues results, broadcasts under CDB grant.
// Optional build macro ALU_PERF_CNT_EN adds exec/taken performance counters.
module alu_exec_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_W      = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rollback_flag_from_rob,
    input  logic [5:0]       inst_name_from_rs,
    input  logic [31:0]      V1_from_rs,
    input  logic [31:0]      V2_from_rs,
    input  logic [31:0]      pc_from_rs,
    input  logic [31:0]      imm_from_rs,
    input  logic [ROB_W-1:0] rob_id_from_rs,
    input  logic             cdb_grant_in,
    output logic             full_to_rs,
    output logic             valid_to_cdb,
    output logic [31:0]      result_to_cdb,
    output logic [ROB_W-1:0] rob_id_to_cdb,
    output logic             jump_flag_to_rob,
    output logic [31:0]      target_pc_to_rob,
    output logic             overflow_err
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_exec_cnt,
    output logic [31:0]      perf_taken_cnt
`endif
);

    // Shared instruction codes; loads/stores are listed only so they decode as "not ours".
    localparam logic [5:0] NOP   = 6'd0,  LUI   = 6'd1,  AUIPC = 6'd2,  JAL   = 6'd3;
    localparam logic [5:0] JALR  = 6'd4,  BEQ   = 6'd5,  BNE   = 6'd6,  BLT   = 6'd7;
    localparam logic [5:0] BGE   = 6'd8,  BLTU  = 6'd9,  BGEU  = 6'd10, LB    = 6'd11;
    localparam logic [5:0] LH    = 6'd12, LW    = 6'd13, LBU   = 6'd14, LHU   = 6'd15;
    localparam logic [5:0] SB    = 6'd16, SH    = 6'd17, SW    = 6'd18, ADDI  = 6'd19;
    localparam logic [5:0] SLTI  = 6'd20, SLTIU = 6'd21, XORI  = 6'd22, ORI   = 6'd23;
    localparam logic [5:0] ANDI  = 6'd24, SLLI  = 6'd25, SRLI  = 6'd26, SRAI  = 6'd27;
    localparam logic [5:0] ADD   = 6'd28, SUB   = 6'd29, SLL   = 6'd30, SLT   = 6'd31;
    localparam logic [5:0] SLTU  = 6'd32, XOR   = 6'd33, SRL   = 6'd34, SRA   = 6'd35;
    localparam logic [5:0] OR    = 6'd36, AND   = 6'd37;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(FIFO_DEPTH - 1);

    logic [31:0] v1, v2, imm, pc, pc4, pc_imm;
    logic [4:0]  sh_r, sh_i;
    logic        op_valid;
    logic [31:0] calc_result;
    logic        calc_jump;
    logic [31:0] calc_target;

    assign v1     = V1_from_rs;
    assign v2     = V2_from_rs;
    assign imm    = imm_from_rs;
    assign pc     = pc_from_rs;
    assign pc4    = pc_from_rs + 32'd4;
    assign pc_imm = pc_from_rs + imm_from_rs;
    assign sh_r   = V2_from_rs[4:0];
    assign sh_i   = imm_from_rs[4:0];

    always_comb begin
        op_valid    = 1'b1;
        calc_result = '0;
        calc_jump   = 1'b0;
        calc_target = pc4;
        case (inst_name_from_rs)
            LUI:   calc_result = imm;
            AUIPC: calc_result = pc + imm;
            JAL: begin
                calc_result = pc4;
                calc_target = pc_imm;
                calc_jump   = 1'b1;
            end
            JALR: begin
                calc_result = pc4;
                calc_target = (v1 + imm) & ~32'h1;
                calc_jump   = 1'b1;
            end
            BEQ:   calc_jump = (v1 == v2);
            BNE:   calc_jump = (v1 != v2);
            BLT:   calc_jump = ($signed(v1) <  $signed(v2));
            BGE:   calc_jump = ($signed(v1) >= $signed(v2));
            BLTU:  calc_jump = (v1 <  v2);
            BGEU:  calc_jump = (v1 >= v2);
            ADD:   calc_result = v1 + v2;
            SUB:   calc_result = v1 - v2;
            SLL:   calc_result = v1 << sh_r;
            SLT:   calc_result = {31'd0, $signed(v1) < $signed(v2)};
            SLTU:  calc_result = {31'd0, v1 < v2};
            XOR:   calc_result = v1 ^ v2;
            SRL:   calc_result = v1 >> sh_r;
            SRA:   calc_result = $signed(v1) >>> sh_r;
            OR:    calc_result = v1 | v2;
            AND:   calc_result = v1 & v2;
            ADDI:  calc_result = v1 + imm;
            SLTI:  calc_result = {31'd0, $signed(v1) < $signed(imm)};
            SLTIU: calc_result = {31'd0, v1 < imm};
            XORI:  calc_result = v1 ^ imm;
            ORI:   calc_result = v1 | imm;
            ANDI:  calc_result = v1 & imm;
            SLLI:  calc_result = v1 << sh_i;
            SRLI:  calc_result = v1 >> sh_i;
            SRAI:  calc_result = $signed(v1) >>> sh_i;
            default: op_valid = 1'b0;
        endcase
        // Branches share the taken/not-taken target selection.
        if (inst_name_from_rs >= BEQ && inst_name_from_rs <= BGEU && calc_jump)
            calc_target = pc_imm;
    end

    logic [31:0]      res_mem [FIFO_DEPTH];
    logic [ROB_W-1:0] rob_mem [FIFO_DEPTH];
    logic             jmp_mem [FIFO_DEPTH];
    logic [31:0]      tgt_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_valid;
    logic             do_pop;
    logic             do_push;

    assign fifo_valid = (count != '0);
    assign do_pop     = rdy_in && !rollback_flag_from_rob && fifo_valid && cdb_grant_in;
    assign do_push    = rdy_in && !rollback_flag_from_rob && op_valid &&
                        ((count < DEPTH_C) || do_pop);

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            res_mem[wr_ptr] <= calc_result;
            rob_mem[wr_ptr] <= rob_id_from_rs;
            jmp_mem[wr_ptr] <= calc_jump;
            tgt_mem[wr_ptr] <= calc_target;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (rdy_in) begin
            if (rollback_flag_from_rob) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (do_push && !do_pop)
                    count <= count + CNT_W'(1);
                else if (do_pop && !do_push)
                    count <= count - CNT_W'(1);
                if (op_valid && count == DEPTH_C && !do_pop)
                    overflow_err <= 1'b1;
            end
        end
    end

`ifdef ALU_PERF_CNT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_exec_cnt  <= '0;
            perf_taken_cnt <= '0;
        end else if (do_push) begin
            perf_exec_cnt <= perf_exec_cnt + 32'd1;
            if (calc_jump)
                perf_taken_cnt <= perf_taken_cnt + 32'd1;
        end
    end
`endif

    // Output fields read zero whenever the queue is empty, including right after reset.
    assign full_to_rs       = (count >= DEPTH_M1_C);
    assign valid_to_cdb     = fifo_valid;
    assign result_to_cdb    = fifo_valid ? res_mem[rd_ptr] : '0;
    assign rob_id_to_cdb    = fifo_valid ? rob_mem[rd_ptr] : '0;
    assign jump_flag_to_rob = fifo_valid ? jmp_mem[rd_ptr] : 1'b0;
    assign target_pc_to_rob = fifo_valid ? tgt_mem[rd_ptr] : '0;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the reservation-station issue port.
- Accepts one issued ALU/branch/jump op per cycle (opcode, V1, V2, pc, imm, rob_id) and computes its result.
- Queues results in a small FIFO and broadcasts them on the ALU result bus (valid/result/rob_id) to the RS, LSU and ROB, under a CDB grant.
- Asserts back-pressure toward the RS issue logic and resolves branch/jump targets for the ROB.

Parameters:
- FIFO_DEPTH, 4, result queue entries (power of two, minimum 2)
- ROB_W, 5, rob id width; id 0 is reserved as "no tag"

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; when low, all state holds
- rollback_flag_from_rob  input  1  flush
- inst_name_from_rs  input  6  opcode from the shared instruction codes; NOP means no issue
- V1_from_rs  input  32  operand 1
- V2_from_rs  input  32  operand 2
- pc_from_rs  input  32  instruction pc
- imm_from_rs  input  32  sign-extended immediate
- rob_id_from_rs  input  ROB_W  destination tag
- cdb_grant_in  input  1  broadcast accepted this cycle
- full_to_rs  output  1  RS must not issue next cycle
- valid_to_cdb  output  1  head entry valid
- result_to_cdb  output  32  head result
- rob_id_to_cdb  output  ROB_W  head tag
- jump_flag_to_rob  output  1  head: control transfer taken
- target_pc_to_rob  output  32  head: next pc
- overflow_err  output  1  sticky: issue arrived while FIFO full

Behaviour:
- Reset (rst_in=1 at posedge): FIFO empty, count=0, overflow_err=0. All outputs 0.
- rdy_in=0 with no reset: no enqueue, no dequeue, outputs hold.
- Rollback (flag=1 at posedge, rdy_in=1): FIFO cleared and same-cycle issue discarded. valid_to_cdb=0 from the next cycle. overflow_err is unaffected. Reset takes priority over rollback.
- Compute is combinational on the RS inputs. The result is enqueued at the posedge of the issue cycle, so latency from issue to valid_to_cdb is 1 cycle when the FIFO is empty.
- Supported ops and results:
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL: result pc+4, target pc+imm, jump=1.
  - JALR: result pc+4, target (V1+imm)&~1, jump=1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: result 0. jump=condition on V1,V2 (signed or unsigned per op). target pc+imm if taken, else pc+4.
  - R-type ADD..AND use V2; I-type ADDI..ANDI use imm.
  - Shifts use amount [4:0] of V2 or imm; SRA/SRAI arithmetic. SLT/SLTU produce 0/1.
  - All arithmetic is modulo 2^32.
  - Non-control ops: jump=0, target pc+4.
- Any other opcode (loads, stores, NOP, unknown) is ignored: no enqueue.
- Broadcast: valid_to_cdb = FIFO non-empty; data and tag fields show the head entry. Head pops at a posedge with valid_to_cdb=1 and cdb_grant_in=1. Grant while empty is ignored.
- Simultaneous enqueue and dequeue: count unchanged, order preserved (strict FIFO).
- full_to_rs = (count >= FIFO_DEPTH-1). This keeps one slot for the op already in flight from the registered RS issue.
- Issue with count==FIFO_DEPTH and no pop the same cycle: op dropped, overflow_err set until reset. Issue with count==FIFO_DEPTH and a pop the same cycle: accepted.
- Read and write pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro ALU_PERF_CNT_EN.
- Defined: adds outputs perf_exec_cnt[31:0] (accepted enqueues) and perf_taken_cnt[31:0] (accepted enqueues with jump=1).
  - Counters are cleared by reset, not by rollback, and frozen while rdy_in=0.
  - They wrap at 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then issue ADD V1=5 V2=7 rob 3 with grant=1 → next cycle valid=1, result 12, rob 3, jump 0, target pc+4; the cycle after, valid=0.
- Issue BLT V1=0xFFFFFFFF V2=1 pc=0x100 imm=0x20 → jump 1, target 0x120. BLTU with the same operands → jump 0, target 0x104.
- Issue JALR V1=0x1001 imm=4 pc=0x200 → result 0x204, target 0x1004, jump 1. SRAI V1=0x80000000 imm=0x24 → 0xF8000000.
- Grant=0, issue 3 ops with tags 1,2,3 → full_to_rs=1 after count reaches 3. 4th op fills the FIFO. 5th op sets overflow_err. Then grant=1 → tags broadcast 1,2,3,4 in consecutive cycles.
- Fill 2 entries, assert rollback together with an issue → next cycle valid=0, count 0, and the issued op is never broadcast.
- rdy_in=0 for 3 cycles with a pending head and grant=1 → head and outputs unchanged; pops resume when rdy_in=1.
